// File: rtl/config_pkg.sv
// Core configuration subset consumed by the meta-predictor update producer.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned INSTR_PER_FETCH;
        bit          RVC;
        bit          DebugEn;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN:            32,
        INSTR_PER_FETCH: 2,
        RVC:             1'b1,
        DebugEn:         1'b1
    };

endpackage

// File: rtl/mbp_update_gen_if.sv
// Checkpoint push, branch resolution and chooser update bundle for mbp_update_gen.
interface mbp_update_gen_if #(
    parameter int unsigned VLEN   = 32,
    parameter int unsigned IPF    = 2,
    parameter int unsigned SLOT_W = 1
);

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    // push/resolve fire on a cycle where valid && ready are both high at the
    // rising edge; valid may rise without waiting for ready, payload is only
    // sampled on the firing edge, and ready never depends on valid.
    logic              push_valid;
    logic              push_ready;
    logic [VLEN-1:0]   push_pc;
    logic [SLOT_W-1:0] push_slot;
    logic              push_local_taken;
    logic              push_global_taken;

    logic              resolve_valid;
    logic              resolve_ready;
    logic [VLEN-1:0]   resolve_pc;
    logic              resolve_taken;

    bht_update_t       bht_update;
    logic [IPF-1:0]    local_correct;
    logic [IPF-1:0]    global_correct;
    logic              fsm_state;

    modport slave (
        input  push_valid, push_pc, push_slot, push_local_taken, push_global_taken,
        input  resolve_valid, resolve_pc, resolve_taken,
        output push_ready, resolve_ready, bht_update, local_correct, global_correct,
        output fsm_state
    );

    modport master (
        output push_valid, push_pc, push_slot, push_local_taken, push_global_taken,
        output resolve_valid, resolve_pc, resolve_taken,
        input  push_ready, resolve_ready, bht_update, local_correct, global_correct,
        input  fsm_state
    );

endinterface

// File: rtl/mbp_update_gen.sv
// Records local/global directions per predicted branch in an in-order queue and
// turns resolved branches into chooser updates with per-slot correctness vectors.
module mbp_update_gen #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    mbp_update_gen_if.slave        bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [15:0]            miss_cnt_o
);

    localparam int unsigned VLEN   = CVA6Cfg.VLEN;
    localparam int unsigned IPF    = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned SLOT_W = CVA6Cfg.RVC ? $clog2(IPF) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {RUN = 1'b0, SEARCH = 1'b1} state_e;

    typedef struct packed {
        logic [VLEN-1:0]   pc;
        logic [SLOT_W-1:0] slot;
        logic              local_taken;
        logic              global_taken;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    state_e            state_q, state_d;
    logic [VLEN-1:0]   hold_pc_q;
    logic              hold_taken_q;
    logic [15:0]       miss_q;
    logic              upd_valid_q, upd_taken_q;
    logic [VLEN-1:0]   upd_pc_q;
    logic [IPF-1:0]    lc_q, gc_q;

    entry_t            head_e;
    logic              empty, push_fire, pop, match, miss, capture, match_taken, emit;
    logic [IPF-1:0]    slot_oh;

    assign head_e    = mem_q[head_q];
    assign empty     = (count_q == '0);
    assign push_fire = bus.push_valid && (count_q < CNT_W'(DEPTH)) && !flush_i;
    assign emit      = match && !(CVA6Cfg.DebugEn && debug_mode_i);
    assign slot_oh   = IPF'(1) << head_e.slot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // A mismatching resolution parks in the hold register while stale heads
    // (branches squashed before reaching execute) are discarded one per cycle.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        match       = 1'b0;
        miss        = 1'b0;
        capture     = 1'b0;
        match_taken = bus.resolve_taken;
        if (flush_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.resolve_valid) begin
                        if (empty) begin
                            miss = 1'b1;
                        end else if (head_e.pc == bus.resolve_pc) begin
                            pop   = 1'b1;
                            match = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            capture = 1'b1;
                            state_d = SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    match_taken = hold_taken_q;
                    if (empty) begin
                        miss    = 1'b1;
                        state_d = RUN;
                    end else if (head_e.pc == hold_pc_q) begin
                        pop     = 1'b1;
                        match   = 1'b1;
                        state_d = RUN;
                    end else begin
                        pop = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        bus.resolve_ready  = (state_q == RUN);
        bus.push_ready     = (count_q < CNT_W'(DEPTH));
        bus.fsm_state      = state_q;
        bus.bht_update     = {upd_valid_q, upd_pc_q, upd_taken_q};
        bus.local_correct  = lc_q;
        bus.global_correct = gc_q;
        count_o            = count_q;
        miss_cnt_o         = miss_q;
    end

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[tail_q] <= '{pc:           bus.push_pc,
                               slot:         bus.push_slot,
                               local_taken:  bus.push_local_taken,
                               global_taken: bus.push_global_taken};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            hold_pc_q    <= '0;
            hold_taken_q <= 1'b0;
            miss_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            lc_q         <= '0;
            gc_q         <= '0;
        end else if (flush_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            hold_pc_q    <= '0;
            hold_taken_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            lc_q         <= '0;
            gc_q         <= '0;
        end else begin
            if (push_fire) tail_q <= tail_q + PTR_W'(1);
            if (pop)       head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_fire) - CNT_W'(pop);
            if (capture) begin
                hold_pc_q    <= bus.resolve_pc;
                hold_taken_q <= bus.resolve_taken;
            end
            if (miss && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
            upd_valid_q <= emit;
            upd_pc_q    <= emit ? head_e.pc : '0;
            upd_taken_q <= emit ? match_taken : 1'b0;
            lc_q        <= (emit && (head_e.local_taken == match_taken))  ? slot_oh : '0;
            gc_q        <= (emit && (head_e.global_taken == match_taken)) ? slot_oh : '0;
        end
    end

endmodule

// File: tb/tb_mbp_update_gen.sv
// Directed scenarios plus a randomized run against a queue-level reference model.
module tb_mbp_update_gen;

    localparam config_pkg::cva6_cfg_t CFG = config_pkg::cva6_cfg_empty;
    localparam int VLEN   = CFG.VLEN;
    localparam int IPF    = CFG.INSTR_PER_FETCH;
    localparam int SLOT_W = CFG.RVC ? $clog2(IPF) : 1;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int W      = VLEN + 1 + 2 * IPF;

    typedef struct packed {
        logic [VLEN-1:0]   pc;
        logic [SLOT_W-1:0] slot;
        logic              lt;
        logic              gt;
    } ent_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             debug_mode_i = 1'b0;
    logic [CNT_W-1:0] count_o;
    logic [15:0]      miss_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;

    ent_t        mq[$];
    logic [W-1:0] exp_q[$];

    mbp_update_gen_if #(.VLEN(VLEN), .IPF(IPF), .SLOT_W(SLOT_W)) bus ();

    mbp_update_gen #(.CVA6Cfg(CFG), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .bus          (bus),
        .count_o      (count_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_valid        = 1'b0;
        bus.push_pc           = '0;
        bus.push_slot         = '0;
        bus.push_local_taken  = 1'b0;
        bus.push_global_taken = 1'b0;
        bus.resolve_valid     = 1'b0;
        bus.resolve_pc        = '0;
        bus.resolve_taken     = 1'b0;
        flush_i               = 1'b0;
    endtask

    task automatic push(input logic [VLEN-1:0] pc, input logic [SLOT_W-1:0] slot,
                        input logic lt, input logic gt);
        bus.push_valid        = 1'b1;
        bus.push_pc           = pc;
        bus.push_slot         = slot;
        bus.push_local_taken  = lt;
        bus.push_global_taken = gt;
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b exp 1", bus.push_ready); end
        checks++; if (bus.resolve_ready !== 1'b1) begin errors++; $display("FAIL reset_resolve_ready got %b exp 1", bus.resolve_ready); end
        checks++; if (bus.bht_update !== '0) begin errors++; $display("FAIL reset_update got %h exp 0", bus.bht_update); end
        checks++; if (miss_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_miss got %0d exp 0", miss_cnt_o); end
        checks++; if ({bus.local_correct, bus.global_correct} !== '0) begin errors++; $display("FAIL reset_vectors got %b/%b exp 0", bus.local_correct, bus.global_correct); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_matched();
        push(32'h80, 1, 1'b1, 1'b0);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL match_count_pre got %0d exp 1", count_o); end
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h80; bus.resolve_taken = 1'b1;
        step();
        bus.resolve_valid = 1'b0;
        checks++; if (bus.bht_update !== {1'b1, 32'h80, 1'b1}) begin errors++; $display("FAIL match_update got %h exp %h", bus.bht_update, {1'b1, 32'h80, 1'b1}); end
        checks++; if (bus.local_correct !== 2'b10) begin errors++; $display("FAIL match_local got %b exp 10", bus.local_correct); end
        checks++; if (bus.global_correct !== 2'b00) begin errors++; $display("FAIL match_global got %b exp 00", bus.global_correct); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL match_count_post got %0d exp 0", count_o); end
        step();
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL match_pulse_width got %b exp 0", bus.bht_update.valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i * 4), 0, 1'b0, 1'b0);
        checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready got %b exp 0", bus.push_ready); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count_o); end
        bus.push_valid = 1'b1; bus.push_pc = 32'h200;
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h100; bus.resolve_taken = 1'b0;
        step();
        bus.resolve_valid = 1'b0;
        checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL full_refused_count got %0d exp 7", count_o); end
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", bus.push_ready); end
        checks++; if (bus.bht_update !== {1'b1, 32'h100, 1'b0} || bus.local_correct !== 2'b01) begin
            errors++; $display("FAIL full_update got %h/%b exp %h/01", bus.bht_update, bus.local_correct, {1'b1, 32'h100, 1'b0}); end
        step();
        bus.push_valid = 1'b0;
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_accept_count got %0d exp 8", count_o); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL full_flush_count got %0d exp 0", count_o); end
    endtask

    task automatic test_stale_skip();
        push(32'h10, 0, 1'b0, 1'b0);
        push(32'h20, 1, 1'b1, 1'b1);
        push(32'h30, 1, 1'b1, 1'b0);
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h30; bus.resolve_taken = 1'b0;
        step();
        bus.resolve_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus.resolve_ready !== 1'b0 || bus.fsm_state !== 1'b1) begin errors++; $display("FAIL stale_search%0d got ready=%b state=%b exp 0/1", c, bus.resolve_ready, bus.fsm_state); end
            checks++; if (count_o !== CNT_W'(2 - c)) begin errors++; $display("FAIL stale_count%0d got %0d exp %0d", c, count_o, 2 - c); end
            checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL stale_early_update%0d got 1 exp 0", c); end
            step();
        end
        checks++; if (bus.bht_update !== {1'b1, 32'h30, 1'b0}) begin errors++; $display("FAIL stale_update got %h exp %h", bus.bht_update, {1'b1, 32'h30, 1'b0}); end
        checks++; if (bus.local_correct !== 2'b00 || bus.global_correct !== 2'b10) begin errors++; $display("FAIL stale_vectors got %b/%b exp 00/10", bus.local_correct, bus.global_correct); end
        checks++; if (count_o !== 4'd0 || bus.resolve_ready !== 1'b1) begin errors++; $display("FAIL stale_end got count=%0d ready=%b exp 0/1", count_o, bus.resolve_ready); end
        step();
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL stale_single_pulse got 1 exp 0"); end
    endtask

    task automatic test_no_match();
        push(32'h10, 0, 1'b0, 1'b0);
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h99; bus.resolve_taken = 1'b1;
        step();
        bus.resolve_valid = 1'b0;
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL nomatch_update0 got 1 exp 0"); end
        step();
        exp_miss++;
        checks++; if (miss_cnt_o !== 16'(exp_miss)) begin errors++; $display("FAIL nomatch_miss got %0d exp %0d", miss_cnt_o, exp_miss); end
        checks++; if (count_o !== 4'd0 || bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL nomatch_drain got count=%0d valid=%b exp 0/0", count_o, bus.bht_update.valid); end
        bus.resolve_valid = 1'b1;
        step();
        bus.resolve_valid = 1'b0;
        exp_miss++;
        checks++; if (miss_cnt_o !== 16'(exp_miss)) begin errors++; $display("FAIL empty_miss got %0d exp %0d", miss_cnt_o, exp_miss); end
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL empty_update got 1 exp 0"); end
    endtask

    task automatic test_flush();
        push(32'h40, 0, 1'b0, 1'b0);
        push(32'h50, 0, 1'b0, 1'b0);
        push(32'h60, 0, 1'b0, 1'b0);
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h50; bus.resolve_taken = 1'b1;
        step();
        bus.resolve_valid = 1'b0;
        checks++; if (bus.fsm_state !== 1'b1) begin errors++; $display("FAIL flush_in_search got %b exp 1", bus.fsm_state); end
        flush_i = 1'b1;
        bus.push_valid = 1'b1; bus.push_pc = 32'h70;
        step();
        flush_i = 1'b0;
        bus.push_valid = 1'b0;
        checks++; if (count_o !== 4'd0 || bus.fsm_state !== 1'b0) begin errors++; $display("FAIL flush_state got count=%0d state=%b exp 0/0", count_o, bus.fsm_state); end
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL flush_suppress got 1 exp 0"); end
        checks++; if (miss_cnt_o !== 16'(exp_miss)) begin errors++; $display("FAIL flush_keeps_miss got %0d exp %0d", miss_cnt_o, exp_miss); end
        step();
        checks++; if (count_o !== 4'd0 || bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL flush_no_push got count=%0d valid=%b exp 0/0", count_o, bus.bht_update.valid); end
    endtask

    task automatic test_debug();
        push(32'h88, 1, 1'b1, 1'b1);
        debug_mode_i = 1'b1;
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h88; bus.resolve_taken = 1'b1;
        step();
        bus.resolve_valid = 1'b0;
        debug_mode_i = 1'b0;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL debug_pop got %0d exp 0", count_o); end
        checks++; if (bus.bht_update.valid !== 1'b0) begin errors++; $display("FAIL debug_valid got 1 exp 0"); end
        checks++; if ({bus.local_correct, bus.global_correct} !== '0) begin errors++; $display("FAIL debug_vectors got %b/%b exp 0", bus.local_correct, bus.global_correct); end
    endtask

    task automatic test_reset_in_search();
        push(32'h10, 0, 1'b0, 1'b0);
        push(32'h20, 0, 1'b0, 1'b0);
        bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h99;
        step();
        bus.resolve_valid = 1'b0;
        rst_ni = 1'b0;
        #2;
        exp_miss = 0;
        checks++; if (bus.resolve_ready !== 1'b1 || count_o !== 4'd0) begin errors++; $display("FAIL reset_search got ready=%b count=%0d exp 1/0", bus.resolve_ready, count_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic model_miss();
        if (exp_miss != 65535) exp_miss++;
    endtask

    task automatic check_random_outputs();
        logic [W-1:0] got, exp;
        if (bus.bht_update.valid) begin
            got = {bus.bht_update.pc, bus.bht_update.taken, bus.local_correct, bus.global_correct};
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rnd_spurious_update got %h exp none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin errors++; $display("FAIL rnd_update got %h exp %h", got, exp); end
            end
        end else if ({bus.local_correct, bus.global_correct} !== '0) begin
            errors++; checks++; $display("FAIL rnd_idle_vectors got %b/%b exp 0", bus.local_correct, bus.global_correct);
        end
        if (bus.resolve_ready) begin
            checks++; if (count_o !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", count_o, mq.size()); end
            checks++; if (miss_cnt_o !== 16'(exp_miss)) begin errors++; $display("FAIL rnd_miss got %0d exp %0d", miss_cnt_o, exp_miss); end
        end
    endtask

    task automatic test_random();
        ent_t e, ne;
        logic push_ok, found, was_empty;
        logic [IPF-1:0] oh;
        mq.delete();
        for (int it = 0; it < 600; it++) begin
            check_random_outputs();
            idle_inputs();
            if (bus.resolve_ready) begin
                if ($urandom_range(0, 39) == 0) begin
                    flush_i = 1'b1;
                    bus.push_valid = 1'($urandom_range(0, 1));
                    mq.delete();
                end else begin
                    bus.push_valid        = ($urandom_range(0, 99) < 55);
                    bus.push_pc           = VLEN'($urandom_range(0, 7) * 4);
                    bus.push_slot         = SLOT_W'($urandom_range(0, IPF - 1));
                    bus.push_local_taken  = 1'($urandom_range(0, 1));
                    bus.push_global_taken = 1'($urandom_range(0, 1));
                    bus.resolve_valid     = ($urandom_range(0, 99) < 40);
                    bus.resolve_pc        = VLEN'($urandom_range(0, 8) * 4);
                    bus.resolve_taken     = 1'($urandom_range(0, 1));
                    ne = '{pc: bus.push_pc, slot: bus.push_slot, lt: bus.push_local_taken, gt: bus.push_global_taken};
                    push_ok   = bus.push_valid && (mq.size() < DEPTH);
                    was_empty = (mq.size() == 0);
                    if (push_ok) mq.push_back(ne);
                    if (bus.resolve_valid) begin
                        if (was_empty) begin
                            model_miss();
                        end else begin
                            found = 1'b0;
                            while (!found && mq.size() > 0) begin
                                e = mq.pop_front();
                                if (e.pc == bus.resolve_pc) begin
                                    found = 1'b1;
                                    oh = '0;
                                    oh[e.slot] = 1'b1;
                                    exp_q.push_back({e.pc, bus.resolve_taken,
                                                     (e.lt == bus.resolve_taken) ? oh : '0,
                                                     (e.gt == bus.resolve_taken) ? oh : '0});
                                end
                            end
                            if (!found) model_miss();
                        end
                    end
                end
            end
            step();
        end
        idle_inputs();
        for (int d = 0; d < 12; d++) begin
            check_random_outputs();
            step();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_missing_updates got 0 exp %0d more", exp_q.size()); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_matched();
        test_full();
        test_stale_skip();
        test_no_match();
        test_flush();
        test_debug();
        test_reset_in_search();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbp_update_gen.md
Name: mbp_update_gen

Overview:
- Producer side of the meta (chooser) predictor update interface.
- At fetch time it records the local and global predictor directions for each predicted branch in an in-order checkpoint queue.
- At branch resolution it matches the resolved branch against the queue head. It then drives the chooser's update struct plus the per-slot local_correct/global_correct vectors, registered one cycle later.
- Sits in the frontend between the fetch-side predictors and the chooser BHT; resolution comes from execute.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; supplies VLEN, INSTR_PER_FETCH, RVC, DebugEn.
- DEPTH, 8: checkpoint queue entries; power of two, at least 2.
- SLOT_W, derived: $clog2(INSTR_PER_FETCH) if RVC, else 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  frontend flush; discards all checkpoints.
- debug_mode_i  in  1  suppresses update output while high (only when DebugEn).
- push_valid_i  in  1  checkpoint push request.
- push_ready_o  out  1  queue not full.
- push_pc_i  in  VLEN  branch PC.
- push_slot_i  in  SLOT_W  fetch slot of the branch.
- push_local_taken_i  in  1  local predictor direction.
- push_global_taken_i  in  1  global predictor direction.
- resolve_valid_i  in  1  resolved branch request.
- resolve_ready_o  out  1  resolution accepted.
- resolve_pc_i  in  VLEN  resolved branch PC.
- resolve_taken_i  in  1  actual outcome.
- bht_update_o  out  bht_update_t  {valid, pc, taken} to the chooser.
- local_correct_o  out  INSTR_PER_FETCH  one-hot at slot: local predictor was correct.
- global_correct_o  out  INSTR_PER_FETCH  one-hot at slot: global predictor was correct.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- miss_cnt_o  out  16  resolutions with no matching checkpoint; saturating.

Behaviour:
- Reset (async) values:
  - queue empty, head = tail = 0, count_o = 0
  - state RUN, miss_cnt_o = 0
  - all outputs 0; push_ready_o = 1
- Queue: circular, head/tail wrap modulo DEPTH.
  - push_ready_o = (count < DEPTH), computed from registered count.
  - A pop in the same cycle does not free space for a same-cycle push at full.
  - A push fires when push_valid_i && push_ready_o; the entry is written at tail and tail advances.
- FSM has two states: RUN and SEARCH.
  - resolve_ready_o = 1 in RUN, 0 in SEARCH.
- RUN, on resolve fire:
  - Queue non-empty and head.pc == resolve_pc_i: pop head and emit an update (below).
  - Queue empty: drop the resolution, miss_cnt++, no update.
  - Queue non-empty and mismatch: capture pc/taken into a hold register, pop the stale head, go to SEARCH.
- SEARCH, each cycle:
  - Queue empty: drop the held resolution, miss_cnt++, go to RUN.
  - Head matches hold: pop, emit update, go to RUN.
  - Otherwise: pop the stale head and stay in SEARCH.
  - Pushes remain allowed during SEARCH.
- Update emission: registered, appears the cycle after the matching pop.
  - bht_update_o.valid = 1 for exactly one cycle.
  - .pc = entry pc.
  - .taken = resolved outcome.
  - local_correct_o[slot] = (local_taken == outcome); global_correct_o[slot] = (global_taken == outcome).
  - All other bits 0; when valid = 0, both vectors are 0.
- Debug: if DebugEn && debug_mode_i, matching still pops but valid is forced 0 and the vectors are 0.
- Flush: highest priority.
  - Same-cycle push and resolve are ignored, with no pop.
  - Next cycle: count 0, head = tail, state RUN, hold discarded, bht_update_o.valid = 0.
  - An update registered in the flush cycle is suppressed.
  - miss_cnt is not cleared by flush.
- miss_cnt saturates at 16'hFFFF.
- Reset mid-SEARCH returns to RUN with an empty queue.
- Push and match-pop in the same cycle: count unchanged.

Test Plan:
- Matched resolve: push pc=0x80, slot 1, local=1, global=0; resolve pc=0x80 taken=1. Next cycle: update valid=1, pc=0x80, taken=1, local_correct=0b10, global_correct=0b00; count 1→0.
- Full queue: push 8 entries; push_ready_o=0. Push with a same-cycle resolve pop is refused; the following cycle push_ready_o=1 and the push is accepted.
- Stale skip: push 0x10, 0x20, 0x30; resolve 0x30. State SEARCH for 2 cycles; 0x10 and 0x20 are discarded; one update for 0x30; count ends at 0; resolve_ready_o low during SEARCH.
- No match: push 0x10; resolve 0x99. Queue drains; miss_cnt_o=1; no update pulse. Resolve on an empty queue gives miss_cnt_o=2.
- Flush: flush_i during SEARCH with 3 entries queued. Next cycle count 0, RUN, no update. A concurrent push is not enqueued.
- Debug: debug_mode_i=1 with a matched resolve. Entry is popped, update valid stays 0, and both vectors are 0.
